programmable_clock_divider: RTL



---
 rtl/programmable_clock_divider_if.sv | 23 ++
 rtl/programmable_clock_divider.sv | 122 ++++++++++++
 2 files changed

// File: rtl/programmable_clock_divider_if.sv
// Control/status bundle for the programmable clock divider: run control,
// divide-value load handshake and the divided clock/tick outputs.
interface programmable_clock_divider_if #(
    parameter int COUNT_WIDTH = 16
);
    logic                   i_Enable;
    logic [COUNT_WIDTH-1:0] i_Div_Value;
    logic                   i_Div_Load;
    logic                   o_Div_Ack;
    logic                   o_Clk_Divided;
    logic                   o_Tick;
    logic                   o_Busy;

    modport slave (
        input  i_Enable, i_Div_Value, i_Div_Load,
        output o_Div_Ack, o_Clk_Divided, o_Tick, o_Busy
    );

    modport master (
        output i_Enable, i_Div_Value, i_Div_Load,
        input  o_Div_Ack, o_Clk_Divided, o_Tick, o_Busy
    );
endinterface

// File: rtl/programmable_clock_divider.sv
// Runtime-programmable clock divider: any integer period >= 2, high phase
// ceil(P/2), new divide values applied glitch-free at period boundaries.
module programmable_clock_divider #(
    parameter int COUNT_WIDTH = 16,
    parameter int DEFAULT_DIV = 4
) (
    input  logic i_Clk_Real,
    input  logic i_Rst_n,
    programmable_clock_divider_if.slave bus
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_e;

    localparam logic [COUNT_WIDTH-1:0] DEF_DIV = COUNT_WIDTH'(DEFAULT_DIV);
    localparam logic [COUNT_WIDTH-1:0] ONE     = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] TWO     = COUNT_WIDTH'(2);

    state_e                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [COUNT_WIDTH-1:0] active_q, active_d;
    logic [COUNT_WIDTH-1:0] pending_q, pending_d;
    logic                   busy_q, busy_d;
    logic                   clk_div_q, clk_div_d;
    logic                   tick_q, tick_d;
    logic                   ack_q, ack_d;

    logic [COUNT_WIDTH-1:0] p_eff, h_len, l_len;
    logic                   enter_high, apply;

    // H is at most 2^(W-1) even for the largest period, so no overflow.
    always_comb begin
        p_eff = (active_q < TWO) ? TWO : active_q;
        l_len = p_eff >> 1;
        h_len = l_len + {{(COUNT_WIDTH-1){1'b0}}, p_eff[0]};
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        active_d   = active_q;
        pending_d  = pending_q;
        busy_d     = busy_q;
        enter_high = 1'b0;
        apply      = 1'b0;
        ack_d      = 1'b0;

        if (!bus.i_Enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d    = HIGH;
                    cnt_d      = ONE;
                    enter_high = 1'b1;
                end
                HIGH: begin
                    if (cnt_q == h_len) begin
                        state_d = LOW;
                        cnt_d   = ONE;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                LOW: begin
                    if (cnt_q == l_len) begin
                        state_d    = HIGH;
                        cnt_d      = ONE;
                        enter_high = 1'b1;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // IDLE edges also apply so software can preconfigure while disabled.
        apply = busy_q && (enter_high || state_q == IDLE);
        if (apply) begin
            active_d = pending_q;
            busy_d   = 1'b0;
            ack_d    = 1'b1;
        end
        if (bus.i_Div_Load) begin
            pending_d = bus.i_Div_Value;
            busy_d    = 1'b1;
        end

        clk_div_d = (state_d == HIGH);
        tick_d    = enter_high;
    end

    always_ff @(posedge i_Clk_Real) begin
        if (!i_Rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            active_q  <= DEF_DIV;
            pending_q <= DEF_DIV;
            busy_q    <= 1'b0;
            clk_div_q <= 1'b0;
            tick_q    <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            busy_q    <= busy_d;
            clk_div_q <= clk_div_d;
            tick_q    <= tick_d;
            ack_q     <= ack_d;
        end
    end

    assign bus.o_Clk_Divided = clk_div_q;
    assign bus.o_Tick        = tick_q;
    assign bus.o_Div_Ack     = ack_q;
    assign bus.o_Busy        = busy_q;
endmodule
